// File: rtl/btn_enable_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_enable_gen_pkg
//  Description : Shared definitions for the push-button enable generator:
//                FSM state encoding and a small helper for sizing counters.
//  Revision    : 1.0  initial release
// ============================================================================
package btn_enable_gen_pkg;

  // Button FSM state encoding (2 bits, fixed values so other lab blocks that
  // decode the state for debug LEDs see the same numbering).
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } btn_state_t;

  // Larger of two unsigned values; used to size the shared repeat counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage : btn_enable_gen_pkg
`default_nettype wire

// File: rtl/btn_enable_gen_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Reusable two-flop synchroniser for a single asynchronous
//                level input. Both flops clear on reset.
//  Ports       : clk   - destination clock
//                reset - asynchronous, active-high reset
//                d     - asynchronous level input
//                q     - synchronised level (two clk edges of latency)
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/btn_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module      : btn_enable_gen
//  Description : Converts a raw bouncing push-button into clean one-clock
//                enable pulses. The button is synchronised, debounced by a
//                four-state FSM, and produces one pulse per accepted press
//                plus optional auto-repeat while the button stays held.
//  Parameters  : DEBOUNCE_CYCLES - stable cycles needed to accept a change
//                HOLD_CYCLES     - cycles from press pulse to first repeat
//                REPEAT_CYCLES   - cycles between subsequent repeats
//                REPEAT_EN       - 1 enables auto-repeat while held
//  Ports       : clk          - system clock
//                reset        - asynchronous, active-high reset
//                btn_in       - raw button level (asynchronous, active-high)
//                enable_pulse - registered one-clock enable pulse
//                btn_level    - registered debounced button level
//  Revision    : 1.0  initial release
// ============================================================================
module btn_enable_gen
  import btn_enable_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 20000000,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic enable_pulse,
  output logic btn_level
);

  // --------------------------------------------------------------------------
  // Counter sizing. Each counter only ever reaches its terminal value minus
  // one before being cleared/reloaded, so max+1 states always fit.
  // --------------------------------------------------------------------------
  localparam int unsigned c_DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned c_RPT_MAX = max_u(HOLD_CYCLES, REPEAT_CYCLES);
  localparam int unsigned c_RPT_W = (c_RPT_MAX > 1) ? $clog2(c_RPT_MAX + 1) : 1;

  localparam logic [c_DEB_W-1:0] c_DEB_LAST    = c_DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_RPT_W-1:0] c_HOLD_LAST   = c_RPT_W'(HOLD_CYCLES - 1);
  localparam logic [c_RPT_W-1:0] c_REPEAT_LAST = c_RPT_W'(REPEAT_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic w_btn_sync;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (w_btn_sync)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  btn_state_t          r_state;
  btn_state_t          w_state_nxt;
  logic [c_DEB_W-1:0]  r_deb_cnt;
  logic [c_DEB_W-1:0]  w_deb_cnt_nxt;
  logic [c_RPT_W-1:0]  r_rpt_cnt;
  logic [c_RPT_W-1:0]  w_rpt_cnt_nxt;
  // 0 while waiting for the first repeat (HOLD period), 1 once repeating.
  logic                r_rpt_phase;
  logic                w_rpt_phase_nxt;
  logic                r_pulse;
  logic                w_pulse_nxt;
  logic                r_level;
  logic                w_level_nxt;
  logic [c_RPT_W-1:0]  w_rpt_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_deb_cnt   <= '0;
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
      r_pulse     <= 1'b0;
      r_level     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_deb_cnt   <= w_deb_cnt_nxt;
      r_rpt_cnt   <= w_rpt_cnt_nxt;
      r_rpt_phase <= w_rpt_phase_nxt;
      r_pulse     <= w_pulse_nxt;
      r_level     <= w_level_nxt;
    end
  end

  // Terminal count for the repeat timer depends on which phase it is in.
  assign w_rpt_last = r_rpt_phase ? c_REPEAT_LAST : c_HOLD_LAST;

  // --------------------------------------------------------------------------
  // Next-state, counter and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_deb_cnt_nxt   = r_deb_cnt;
    w_rpt_cnt_nxt   = r_rpt_cnt;
    w_rpt_phase_nxt = r_rpt_phase;
    w_pulse_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_btn_sync) begin
          w_state_nxt   = ST_DEB_PRESS;
          w_deb_cnt_nxt = '0;
        end
      end

      ST_DEB_PRESS: begin
        if (!w_btn_sync) begin
          // Glitch shorter than the debounce window: drop it silently.
          w_state_nxt = ST_IDLE;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          w_state_nxt     = ST_HELD;
          w_pulse_nxt     = 1'b1;
          w_rpt_cnt_nxt   = '0;
          w_rpt_phase_nxt = 1'b0;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + 1'b1;
        end
      end

      ST_HELD: begin
        if (!w_btn_sync) begin
          w_state_nxt   = ST_DEB_RELEASE;
          w_deb_cnt_nxt = '0;
        end else if (REPEAT_EN) begin
          if (r_rpt_cnt == w_rpt_last) begin
            // Guard keeps pulses separated even with 1-cycle hold/repeat.
            w_pulse_nxt     = !r_pulse;
            w_rpt_cnt_nxt   = '0;
            w_rpt_phase_nxt = 1'b1;
          end else begin
            w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
          end
        end
      end

      ST_DEB_RELEASE: begin
        if (w_btn_sync) begin
          // Bounce during release: button still held, restart repeat timer.
          w_state_nxt   = ST_HELD;
          w_rpt_cnt_nxt = '0;
        end else if (r_deb_cnt == c_DEB_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Debounced level is registered from the next state so it rises and
    // falls on the same edge the FSM accepts the change.
    w_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_DEB_RELEASE);
  end

  assign enable_pulse = r_pulse;
  assign btn_level    = r_level;

endmodule : btn_enable_gen
`default_nettype wire

// File: tb/tb_btn_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_enable_gen
//  Description : Self-checking bench for btn_enable_gen. Two instances share
//                the button stimulus: one without and one with auto-repeat.
//                A reference model predicts pulse and level-change edges
//                into queues; a monitor pops and compares as the DUTs act.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_enable_gen;

  localparam int D = 4;
  localparam int H = 8;
  localparam int R = 4;

  typedef struct {
    int e;
    bit v;
  } lev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic [1:0] pulse;
  logic [1:0] level;

  always #5 clk = ~clk;

  btn_enable_gen #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R),
    .REPEAT_EN       (1'b0)
  ) u_dut0 (
    .clk          (clk),
    .reset        (rst),
    .btn_in       (btn),
    .enable_pulse (pulse[0]),
    .btn_level    (level[0])
  );

  btn_enable_gen #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R),
    .REPEAT_EN       (1'b1)
  ) u_dut1 (
    .clk          (clk),
    .reset        (rst),
    .btn_in       (btn),
    .enable_pulse (pulse[1]),
    .btn_level    (level[1])
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;        // edge counter, advances only outside reset
  int   pq [2][$];        // expected pulse edges per instance
  lev_t lq [2][$];        // expected level changes per instance
  int   seen [2][$];      // observed pulse edges (for directed checks)
  int   lseen [2][$];     // observed level-change edges

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 2; i++) begin
      seen[i].delete();
      lseen[i].delete();
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: run-length view of the synchronised button. A change is
  // accepted once the opposite value has been seen D+1 edges in a row; the
  // repeat timer measures edges since the press or last repeat, restarting
  // whenever a release bounce is rejected.
  // --------------------------------------------------------------------------
  initial begin : model
    bit m_s1, m_s2, m_prev, m_lvl, m_first, run_val, v, held;
    int run_len, m_start;
    m_s1 = 0; m_s2 = 0; m_prev = 0; m_lvl = 0; m_first = 1;
    run_val = 0; run_len = 0; m_start = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = 0; m_s2 = 0; m_prev = 0; m_lvl = 0; m_first = 1;
        run_val = 0; run_len = 0;
      end else begin
        v    = m_s2;
        m_s2 = m_s1;
        m_s1 = btn;
        cyc++;
        if (v == run_val) run_len++;
        else begin
          run_val = v;
          run_len = 1;
        end
        held = m_lvl && m_prev;
        if (!m_lvl && v && run_len >= D + 1) begin
          m_lvl = 1;
          for (int i = 0; i < 2; i++) begin
            lq[i].push_back('{cyc, 1'b1});
            pq[i].push_back(cyc);
          end
          m_start = cyc;
          m_first = 1;
        end else if (m_lvl && !v && run_len >= D + 1) begin
          m_lvl = 0;
          for (int i = 0; i < 2; i++) lq[i].push_back('{cyc, 1'b0});
        end else if (m_lvl && v) begin
          if (!held) begin
            m_start = cyc;
          end else if (cyc - m_start == (m_first ? H : R)) begin
            pq[1].push_back(cyc);
            m_start = cyc;
            m_first = 0;
          end
        end
        m_prev = v;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: compares DUT activity against the queued predictions.
  // --------------------------------------------------------------------------
  initial begin : monitor
    bit   prev_lvl [2];
    lev_t e;
    prev_lvl[0] = 0;
    prev_lvl[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          check($sformatf("rst_pulse%0d", i), int'(pulse[i]), 0);
          check($sformatf("rst_level%0d", i), int'(level[i]), 0);
          prev_lvl[i] = 0;
        end else begin
          if (pulse[i]) begin
            seen[i].push_back(cyc);
            if (pq[i].size() == 0)
              check($sformatf("pulse_unexpected%0d", i), int'(pulse[i]), 0);
            else
              check($sformatf("pulse_edge%0d", i), cyc, pq[i].pop_front());
          end else if (pq[i].size() != 0 && pq[i][0] <= cyc) begin
            check($sformatf("pulse_missing%0d@%0d", i, pq[i][0]), int'(pulse[i]), 1);
            void'(pq[i].pop_front());
          end

          if (level[i] != prev_lvl[i]) begin
            lseen[i].push_back(cyc);
            if (lq[i].size() == 0) begin
              check($sformatf("level_unexpected%0d", i), int'(level[i]), int'(prev_lvl[i]));
            end else begin
              e = lq[i].pop_front();
              check($sformatf("level_edge%0d", i), cyc, e.e);
              check($sformatf("level_value%0d", i), int'(level[i]), int'(e.v));
            end
          end else if (lq[i].size() != 0 && lq[i][0].e <= cyc) begin
            check($sformatf("level_missing%0d@%0d", i, lq[i][0].e), int'(level[i]), int'(lq[i][0].v));
            void'(lq[i].pop_front());
          end
          prev_lvl[i] = level[i];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stim
    int base;
    int exp4 [6];
    exp4 = '{6, 14, 18, 22, 26, 30};

    // Held in reset with the button pressed: outputs must stay low.
    rst = 1'b1;
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(10);

    // Single press held 20 cycles.
    clear_seen();
    base = cyc + 1;
    btn  = 1'b1;
    tick(20);
    btn = 1'b0;
    tick(20);
    check("t2_pulse_count0", seen[0].size(), 1);
    if (seen[0].size() > 0) check("t2_pulse_edge0", seen[0][0] - base, 6);
    check("t2_level_changes0", lseen[0].size(), 2);
    if (lseen[0].size() == 2) begin
      check("t2_level_rise0", lseen[0][0] - base, 6);
      check("t2_level_fall0", lseen[0][1] - base, 26);
    end
    check("t2_pulse_count1", seen[1].size(), 3);
    if (seen[1].size() == 3) check("t2_last_repeat1", seen[1][2] - base, 18);

    // Short glitch: rejected.
    clear_seen();
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(12);
    check("t3_pulses0", seen[0].size(), 0);
    check("t3_pulses1", seen[1].size(), 0);
    check("t3_level0", lseen[0].size(), 0);

    // Auto-repeat: held for edges 0..29.
    clear_seen();
    base = cyc + 1;
    btn  = 1'b1;
    tick(30);
    btn = 1'b0;
    tick(20);
    check("t4_pulse_count1", seen[1].size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < seen[1].size()) check($sformatf("t4_repeat%0d", k), seen[1][k] - base, exp4[k]);
    check("t4_pulse_count0", seen[0].size(), 1);

    // Release bounce after an accepted press.
    clear_seen();
    btn = 1'b1;
    tick(12);
    btn = 1'b0;
    tick(2);
    btn = 1'b1;
    tick(10);
    check("t5_level_changes0", lseen[0].size(), 1);
    check("t5_pulse_count0", seen[0].size(), 1);
    btn = 1'b0;
    tick(20);

    // Reset while held, then fresh press after reset.
    btn = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("t6_level_before_rst", int'(level[0]), 1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_level0", int'(level[0]), 0);
    check("t6_rst_level1", int'(level[1]), 0);
    check("t6_rst_pulse0", int'(pulse[0]), 0);
    @(negedge clk);
    tick(2);
    #2 rst = 1'b0;
    clear_seen();
    base = cyc + 1;
    tick(12);
    check("t6_pulse_count0", seen[0].size(), 1);
    if (seen[0].size() > 0) check("t6_pulse_edge0", seen[0][0] - base, 6);
    if (seen[1].size() > 0) check("t6_pulse_edge1", seen[1][0] - base, 6);
    btn = 1'b0;
    tick(20);

    // Randomised bouncing, long holds and occasional resets.
    repeat (150) begin
      btn = ~btn;
      tick($urandom_range(1, 12));
      if ($urandom_range(0, 5) == 0) tick($urandom_range(15, 40));
      if ($urandom_range(0, 40) == 0) begin
        #2 rst = 1'b1;
        tick(2);
        #2 rst = 1'b0;
        @(negedge clk);
      end
    end

    btn = 1'b0;
    tick(30);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("drain_pulse_q%0d", i), pq[i].size(), 0);
      check($sformatf("drain_level_q%0d", i), lq[i].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_btn_enable_gen
`default_nettype wire
